// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback sources, issue-stage query and register-file write port
// slave: arbiter side (takes a_*/b_* writes and issue_* queries, drives readys, stall, rd/writeData/isWb, busy)
// master: environment side (the opposite directions)
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic                 a_valid;
   logic [ADDR_W-1:0]    a_rd;
   logic [DATA_W-1:0]    a_data;
   logic                 a_ready;
   logic                 b_valid;
   logic [ADDR_W-1:0]    b_rd;
   logic [DATA_W-1:0]    b_data;
   logic                 b_ready;
   logic                 issue_valid;
   logic [ADDR_W-1:0]    issue_rs1;
   logic [ADDR_W-1:0]    issue_rs2;
   logic [ADDR_W-1:0]    issue_rd;
   logic                 issue_stall;
   logic [ADDR_W-1:0]    rd;
   logic [DATA_W-1:0]    writeData;
   logic                 isWb;
   logic [2**ADDR_W-1:0] busy;
   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  issue_valid, issue_rs1, issue_rs2, issue_rd,
      output a_ready, b_ready, issue_stall, rd, writeData, isWb, busy
   );
   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output issue_valid, issue_rs1, issue_rs2, issue_rd,
      input  a_ready, b_ready, issue_stall, rd, writeData, isWb, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with per-register busy scoreboard
// clk: clock; reset: synchronous active-low reset
// bus.a_*/b_*: writeback sources (valid/ready); bus.issue_*: hazard query, bus.issue_stall answer
// bus.rd/writeData/isWb: registered register-file write port; bus.busy: scoreboard
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input logic                clk,
   input logic                reset,
   regfile_wb_arbiter_if.slave bus
);
   localparam int NR = 2**ADDR_W;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] rd_q, rd_d, g_rd;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              is_wb_q, is_wb_d;
   logic [NR-1:0]     busy_q, busy_d, set_mask, clr_mask;
   logic              a_gnt, b_gnt, stall, accept;
   // last_grant_q = 1 means B won most recently, so A wins the next contention
   always_comb begin
      a_gnt = reset && bus.a_valid && (!bus.b_valid || last_grant_q);
      b_gnt = reset && bus.b_valid && !a_gnt;
      g_rd = a_gnt ? bus.a_rd : bus.b_rd;
      stall = bus.issue_valid && (!reset || busy_q[bus.issue_rs1] || busy_q[bus.issue_rs2] || busy_q[bus.issue_rd]);
      accept = bus.issue_valid && !stall;
      set_mask = (accept && bus.issue_rd != '0) ? NR'(1) << bus.issue_rd : '0;
      clr_mask = is_wb_q ? NR'(1) << rd_q : '0;
      // set is applied after clear so a same-cycle set wins
      busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NR'(1);
      last_grant_d = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_grant_q;
      rd_d = (a_gnt || b_gnt) ? g_rd : rd_q;
      write_data_d = a_gnt ? bus.a_data : b_gnt ? bus.b_data : write_data_q;
      is_wb_d = (a_gnt || b_gnt) && g_rd != '0;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
         rd_q <= '0;
         write_data_q <= '0;
         is_wb_q <= 1'b0;
         busy_q <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_q <= rd_d;
         write_data_q <= write_data_d;
         is_wb_q <= is_wb_d;
         busy_q <= busy_d;
      end
   end
   assign bus.a_ready = a_gnt;
   assign bus.b_ready = b_gnt;
   assign bus.issue_stall = stall;
   assign bus.rd = rd_q;
   assign bus.writeData = write_data_q;
   assign bus.isWb = is_wb_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter against a behavioural model
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus();
   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   int checks = 0;
   int errors = 0;
   bit mb[16];
   bit prefer_a;
   bit primed = 1'b0;
   bit m_wb;
   logic [3:0] m_rd;
   logic [31:0] m_data;
   bit ga, gb;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   function automatic logic [15:0] busy_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = mb[i];
      return v;
   endfunction
   task automatic model_check();
      bit st;
      ga = reset && bus.a_valid && (!bus.b_valid || prefer_a);
      gb = reset && bus.b_valid && (!bus.a_valid || !prefer_a);
      st = bus.issue_valid && (!reset || mb[bus.issue_rs1] || mb[bus.issue_rs2] || mb[bus.issue_rd]);
      chk("m_a_ready", 32'(bus.a_ready), 32'(ga));
      chk("m_b_ready", 32'(bus.b_ready), 32'(gb));
      chk("m_issue_stall", 32'(bus.issue_stall), 32'(st));
      if (primed) begin
         chk("m_isWb", 32'(bus.isWb), 32'(m_wb));
         chk("m_rd", 32'(bus.rd), 32'(m_rd));
         chk("m_writeData", bus.writeData, m_data);
         chk("m_busy", 32'(bus.busy), 32'(busy_vec()));
      end
   endtask
   task automatic model_update();
      bit acc;
      if (!reset) begin
         foreach (mb[i]) mb[i] = 1'b0;
         prefer_a = 1'b1;
         m_wb = 1'b0;
         m_rd = '0;
         m_data = '0;
         primed = 1'b1;
      end else begin
         acc = bus.issue_valid && !(mb[bus.issue_rs1] || mb[bus.issue_rs2] || mb[bus.issue_rd]);
         if (m_wb) mb[m_rd] = 1'b0;
         if (acc && bus.issue_rd != 0) mb[bus.issue_rd] = 1'b1;
         if (ga || gb) begin
            m_rd = ga ? bus.a_rd : bus.b_rd;
            m_data = ga ? bus.a_data : bus.b_data;
            m_wb = m_rd != 0;
            prefer_a = gb;
         end else m_wb = 1'b0;
      end
   endtask
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask
   function automatic logic [3:0] pick_rd();
      int s = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0)
         for (int k = 0; k < 16; k++) if (mb[(s + k) % 16]) return 4'((s + k) % 16);
      return 4'(s);
   endfunction
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h11;
      bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 32'h22;
      bus.issue_valid = 1; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 2;
      step();
      step();
      chk("rst_isWb", 32'(bus.isWb), 0);
      chk("rst_rd", 32'(bus.rd), 0);
      chk("rst_writeData", bus.writeData, 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_a_ready", 32'(bus.a_ready), 0);
      chk("rst_b_ready", 32'(bus.b_ready), 0);
      chk("rst_stall", 32'(bus.issue_stall), 1);
      bus.issue_valid = 0;
      reset = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("cont_a_ready", 32'(bus.a_ready), (i % 2 == 0) ? 1 : 0);
         chk("cont_b_ready", 32'(bus.b_ready), (i % 2 == 0) ? 0 : 1);
         step();
         chk("cont_rd", 32'(bus.rd), (i % 2 == 0) ? 3 : 5);
         chk("cont_writeData", bus.writeData, (i % 2 == 0) ? 32'h11 : 32'h22);
         chk("cont_isWb", 32'(bus.isWb), 1);
      end
      bus.b_valid = 0; bus.a_rd = 0; bus.a_data = 32'hDEAD;
      #1;
      chk("r0_a_ready", 32'(bus.a_ready), 1);
      step();
      bus.a_valid = 0;
      chk("r0_isWb", 32'(bus.isWb), 0);
      chk("r0_busy", 32'(bus.busy), 0);
      bus.issue_valid = 1; bus.issue_rd = 7;
      #1;
      chk("raw_accept", 32'(bus.issue_stall), 0);
      step();
      bus.issue_rs1 = 7; bus.issue_rd = 1;
      #1;
      chk("raw_busy7", 32'(bus.busy), 32'h80);
      chk("raw_stall", 32'(bus.issue_stall), 1);
      step(); step(); step();
      bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'h77;
      #1;
      chk("raw_b_ready", 32'(bus.b_ready), 1);
      step();
      bus.b_valid = 0;
      chk("raw_wb_isWb", 32'(bus.isWb), 1);
      chk("raw_wb_rd", 32'(bus.rd), 7);
      chk("raw_wb_data", bus.writeData, 32'h77);
      chk("raw_still_stall", 32'(bus.issue_stall), 1);
      step();
      chk("raw_cleared", 32'(bus.busy), 0);
      chk("raw_released", 32'(bus.issue_stall), 0);
      bus.issue_rs1 = 0; bus.issue_rd = 9;
      step();
      chk("waw_busy9", 32'(bus.busy), 32'h200);
      chk("waw_stall", 32'(bus.issue_stall), 1);
      bus.a_valid = 1; bus.a_rd = 9; bus.a_data = 32'h99;
      step();
      bus.a_valid = 0;
      chk("waw_wb", 32'(bus.isWb), 1);
      chk("waw_stall_wb", 32'(bus.issue_stall), 1);
      step();
      chk("waw_cleared", 32'(bus.busy), 0);
      chk("waw_released", 32'(bus.issue_stall), 0);
      step();
      bus.issue_valid = 0;
      chk("waw_reissued", 32'(bus.busy), 32'h200);
      reset = 0;
      step();
      reset = 1;
      bus.issue_valid = 1; bus.issue_rd = 3;
      step();
      bus.issue_rd = 5;
      step();
      bus.issue_rd = 7;
      step();
      bus.issue_valid = 0;
      chk("mid_busy", 32'(bus.busy), 32'hA8);
      bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'h33;
      #1;
      chk("mid_a_ready", 32'(bus.a_ready), 1);
      step();
      bus.a_valid = 0;
      reset = 0;
      step();
      chk("mid_isWb", 32'(bus.isWb), 0);
      chk("mid_busy_clr", 32'(bus.busy), 0);
      chk("mid_rd", 32'(bus.rd), 0);
      reset = 1;
      step();
      chk("mid_no_write", 32'(bus.isWb), 0);
      for (int n = 0; n < 2000; n++) begin
         reset = $urandom_range(0, 99) != 0;
         if (!bus.a_valid || ga) begin
            bus.a_valid = $urandom_range(0, 2) != 0; bus.a_rd = pick_rd(); bus.a_data = $urandom;
         end
         if (!bus.b_valid || gb) begin
            bus.b_valid = $urandom_range(0, 2) != 0; bus.b_rd = pick_rd(); bus.b_data = $urandom;
         end
         bus.issue_valid = $urandom_range(0, 1) != 0;
         bus.issue_rs1 = 4'($urandom_range(0, 15));
         bus.issue_rs2 = 4'($urandom_range(0, 15));
         bus.issue_rd = 4'($urandom_range(0, 15));
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
